// File: rtl/e203_soc_top.sv
// SoC always-on shell: ICB register file (GPIO, CLINT timer/soft irq, status) plus constant pad ties.
// Optional macro E203_GPIOB_EN adds the GPIOB register bank, pads and its interrupt contribution.
module e203_soc_top #(
  parameter int LF_SYNC_STAGES = 2
) (
  input  logic        hfextclk,
  input  logic        aon_erst,
  input  logic        lfextclk,
  output logic        hfxoscen,
  output logic        lfxoscen,
  input  logic        icb_cmd_valid,
  output logic        icb_cmd_ready,
  input  logic [11:0] icb_cmd_addr,
  input  logic        icb_cmd_read,
  input  logic [31:0] icb_cmd_wdata,
  input  logic [3:0]  icb_cmd_wmask,
  output logic        icb_rsp_valid,
  input  logic        icb_rsp_ready,
  output logic [31:0] icb_rsp_rdata,
  output logic        icb_rsp_err,
  output logic        clint_sft_irq,
  output logic        clint_tmr_irq,
  output logic        plic_ext_irq,
  input  logic [31:0] io_pads_gpioA_i_ival,
  output logic [31:0] io_pads_gpioA_o_oval,
  output logic [31:0] io_pads_gpioA_o_oe,
  input  logic [31:0] io_pads_gpioB_i_ival,
  output logic [31:0] io_pads_gpioB_o_oval,
  output logic [31:0] io_pads_gpioB_o_oe,
  input  logic        io_pads_jtag_TCK_i_ival,
  input  logic        io_pads_jtag_TMS_i_ival,
  input  logic        io_pads_jtag_TDI_i_ival,
  output logic        io_pads_jtag_TDO_o_oval,
  output logic        io_pads_jtag_TDO_o_oe,
  output logic        io_pads_qspi0_sck_o_oval,
  output logic        io_pads_qspi0_cs_0_o_oval,
  input  logic        io_pads_qspi0_dq_0_i_ival,
  output logic        io_pads_qspi0_dq_0_o_oval,
  output logic        io_pads_qspi0_dq_0_o_oe,
  input  logic        io_pads_qspi0_dq_1_i_ival,
  output logic        io_pads_qspi0_dq_1_o_oval,
  output logic        io_pads_qspi0_dq_1_o_oe,
  input  logic        io_pads_qspi0_dq_2_i_ival,
  output logic        io_pads_qspi0_dq_2_o_oval,
  output logic        io_pads_qspi0_dq_2_o_oe,
  input  logic        io_pads_qspi0_dq_3_i_ival,
  output logic        io_pads_qspi0_dq_3_o_oval,
  output logic        io_pads_qspi0_dq_3_o_oe,
  input  logic        io_pads_aon_pmu_dwakeup_n_i_ival,
  input  logic        io_pads_bootrom_n_i_ival,
  input  logic        io_pads_dbgmode0_n_i_ival,
  input  logic        io_pads_dbgmode1_n_i_ival,
  input  logic        io_pads_dbgmode2_n_i_ival,
  output logic        io_pads_aon_pmu_vddpaden_o_oval,
  output logic        io_pads_aon_pmu_padrst_o_oval
);

  localparam logic [9:0] A_GPIOA_IN  = 10'd0;
  localparam logic [9:0] A_GPIOA_OUT = 10'd1;
  localparam logic [9:0] A_GPIOA_OE  = 10'd2;
  localparam logic [9:0] A_GPIOA_IEN = 10'd3;
  localparam logic [9:0] A_GPIOB_IN  = 10'd4;
  localparam logic [9:0] A_GPIOB_OUT = 10'd5;
  localparam logic [9:0] A_GPIOB_OE  = 10'd6;
  localparam logic [9:0] A_GPIOB_IEN = 10'd7;
  localparam logic [9:0] A_MSIP      = 10'd8;
  localparam logic [9:0] A_MTIME_LO  = 10'd9;
  localparam logic [9:0] A_MTIME_HI  = 10'd10;
  localparam logic [9:0] A_CMP_LO    = 10'd11;
  localparam logic [9:0] A_CMP_HI    = 10'd12;
  localparam logic [9:0] A_STATUS    = 10'd13;

  function automatic logic [31:0] wmerge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] m);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = m[b] ? wd[8*b +: 8] : old[8*b +: 8];
    return r;
  endfunction

  logic [31:0] gpioa_s1_q, gpioa_in_q, gpioa_out_q, gpioa_oe_q, gpioa_ien_q;
  logic [31:0] gpioa_out_d, gpioa_oe_d, gpioa_ien_d;
  logic [31:0] gpiob_in_q, gpiob_out_q, gpiob_oe_q, gpiob_ien_q;
  logic [4:0]  sts_s1_q, sts_q;
  logic        msip_q, msip_d;
  logic [63:0] mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
  logic [LF_SYNC_STAGES-1:0] lf_sync_q;
  logic        lf_prev_q, lf_rise;
  logic        rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        tmr_irq_q, ext_irq_q, padrst_q, ext_irq_d;
  logic [9:0]  word;
  logic        hit, cmd_accept, wr_en;
  logic [31:0] rd_sel;
  logic        unused_ins;

`ifdef E203_GPIOB_EN
  logic [31:0] gpiob_s1_q, gpiob_out_d, gpiob_oe_d, gpiob_ien_d;
  assign unused_ins = ^{io_pads_jtag_TCK_i_ival, io_pads_jtag_TMS_i_ival, io_pads_jtag_TDI_i_ival,
                        io_pads_qspi0_dq_0_i_ival, io_pads_qspi0_dq_1_i_ival,
                        io_pads_qspi0_dq_2_i_ival, io_pads_qspi0_dq_3_i_ival};
`else
  assign gpiob_in_q  = '0;
  assign gpiob_out_q = '0;
  assign gpiob_oe_q  = '0;
  assign gpiob_ien_q = '0;
  assign unused_ins = ^{io_pads_jtag_TCK_i_ival, io_pads_jtag_TMS_i_ival, io_pads_jtag_TDI_i_ival,
                        io_pads_qspi0_dq_0_i_ival, io_pads_qspi0_dq_1_i_ival,
                        io_pads_qspi0_dq_2_i_ival, io_pads_qspi0_dq_3_i_ival,
                        io_pads_gpioB_i_ival, gpiob_in_q, gpiob_ien_q};
`endif

  assign icb_cmd_ready = ~rsp_valid_q | icb_rsp_ready;
  assign cmd_accept    = icb_cmd_valid & icb_cmd_ready;
  assign word          = icb_cmd_addr[11:2];
  assign wr_en         = cmd_accept & ~icb_cmd_read & hit;
  assign lf_rise       = lf_sync_q[LF_SYNC_STAGES-1] & ~lf_prev_q;

  always_comb begin
    hit    = 1'b1;
    rd_sel = '0;
    case (word)
      A_GPIOA_IN:  rd_sel = gpioa_in_q;
      A_GPIOA_OUT: rd_sel = gpioa_out_q;
      A_GPIOA_OE:  rd_sel = gpioa_oe_q;
      A_GPIOA_IEN: rd_sel = gpioa_ien_q;
`ifdef E203_GPIOB_EN
      A_GPIOB_IN:  rd_sel = gpiob_in_q;
      A_GPIOB_OUT: rd_sel = gpiob_out_q;
      A_GPIOB_OE:  rd_sel = gpiob_oe_q;
      A_GPIOB_IEN: rd_sel = gpiob_ien_q;
`endif
      A_MSIP:      rd_sel = {31'd0, msip_q};
      A_MTIME_LO:  rd_sel = mtime_q[31:0];
      A_MTIME_HI:  rd_sel = mtime_q[63:32];
      A_CMP_LO:    rd_sel = mtimecmp_q[31:0];
      A_CMP_HI:    rd_sel = mtimecmp_q[63:32];
      A_STATUS:    rd_sel = {27'd0, sts_q};
      default:     hit = 1'b0;
    endcase
    if (icb_cmd_addr[1:0] != 2'b00) hit = 1'b0;
  end

  always_comb begin
    gpioa_out_d = gpioa_out_q;
    gpioa_oe_d  = gpioa_oe_q;
    gpioa_ien_d = gpioa_ien_q;
    msip_d      = msip_q;
    mtimecmp_d  = mtimecmp_q;
    // A bus write to a timer half overrides the tick for that half.
    mtime_d     = mtime_q + {63'd0, lf_rise};
    if (wr_en) begin
      case (word)
        A_GPIOA_OUT: gpioa_out_d = wmerge(gpioa_out_q, icb_cmd_wdata, icb_cmd_wmask);
        A_GPIOA_OE:  gpioa_oe_d  = wmerge(gpioa_oe_q, icb_cmd_wdata, icb_cmd_wmask);
        A_GPIOA_IEN: gpioa_ien_d = wmerge(gpioa_ien_q, icb_cmd_wdata, icb_cmd_wmask);
        A_MSIP:      if (icb_cmd_wmask[0]) msip_d = icb_cmd_wdata[0];
        A_MTIME_LO:  mtime_d[31:0]     = wmerge(mtime_q[31:0], icb_cmd_wdata, icb_cmd_wmask);
        A_MTIME_HI:  mtime_d[63:32]    = wmerge(mtime_q[63:32], icb_cmd_wdata, icb_cmd_wmask);
        A_CMP_LO:    mtimecmp_d[31:0]  = wmerge(mtimecmp_q[31:0], icb_cmd_wdata, icb_cmd_wmask);
        A_CMP_HI:    mtimecmp_d[63:32] = wmerge(mtimecmp_q[63:32], icb_cmd_wdata, icb_cmd_wmask);
        default: ;
      endcase
    end
  end

`ifdef E203_GPIOB_EN
  always_comb begin
    gpiob_out_d = gpiob_out_q;
    gpiob_oe_d  = gpiob_oe_q;
    gpiob_ien_d = gpiob_ien_q;
    if (wr_en && word == A_GPIOB_OUT) gpiob_out_d = wmerge(gpiob_out_q, icb_cmd_wdata, icb_cmd_wmask);
    if (wr_en && word == A_GPIOB_OE)  gpiob_oe_d  = wmerge(gpiob_oe_q, icb_cmd_wdata, icb_cmd_wmask);
    if (wr_en && word == A_GPIOB_IEN) gpiob_ien_d = wmerge(gpiob_ien_q, icb_cmd_wdata, icb_cmd_wmask);
  end

  always_ff @(posedge hfextclk) begin
    if (aon_erst) begin
      gpiob_s1_q  <= '0;
      gpiob_in_q  <= '0;
      gpiob_out_q <= '0;
      gpiob_oe_q  <= '0;
      gpiob_ien_q <= '0;
    end else begin
      gpiob_s1_q  <= io_pads_gpioB_i_ival;
      gpiob_in_q  <= gpiob_s1_q;
      gpiob_out_q <= gpiob_out_d;
      gpiob_oe_q  <= gpiob_oe_d;
      gpiob_ien_q <= gpiob_ien_d;
    end
  end
`endif

  assign ext_irq_d = (|(gpioa_in_q & gpioa_ien_q)) | (|(gpiob_in_q & gpiob_ien_q));

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (cmd_accept) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = (icb_cmd_read & hit) ? rd_sel : 32'd0;
      rsp_err_d   = ~hit;
    end else if (icb_rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge hfextclk) begin
    padrst_q <= aon_erst;
    if (aon_erst) begin
      gpioa_s1_q  <= '0;
      gpioa_in_q  <= '0;
      gpioa_out_q <= '0;
      gpioa_oe_q  <= '0;
      gpioa_ien_q <= '0;
      sts_s1_q    <= '0;
      sts_q       <= '0;
      msip_q      <= 1'b0;
      mtime_q     <= '0;
      mtimecmp_q  <= '1;
      lf_sync_q   <= '0;
      lf_prev_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      tmr_irq_q   <= 1'b0;
      ext_irq_q   <= 1'b0;
    end else begin
      gpioa_s1_q  <= io_pads_gpioA_i_ival;
      gpioa_in_q  <= gpioa_s1_q;
      gpioa_out_q <= gpioa_out_d;
      gpioa_oe_q  <= gpioa_oe_d;
      gpioa_ien_q <= gpioa_ien_d;
      sts_s1_q    <= {io_pads_aon_pmu_dwakeup_n_i_ival, io_pads_dbgmode2_n_i_ival,
                      io_pads_dbgmode1_n_i_ival, io_pads_dbgmode0_n_i_ival,
                      io_pads_bootrom_n_i_ival};
      sts_q       <= sts_s1_q;
      msip_q      <= msip_d;
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      lf_sync_q   <= {lf_sync_q[LF_SYNC_STAGES-2:0], lfextclk};
      lf_prev_q   <= lf_sync_q[LF_SYNC_STAGES-1];
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      tmr_irq_q   <= (mtime_q >= mtimecmp_q);
      ext_irq_q   <= ext_irq_d;
    end
  end

  assign icb_rsp_valid = rsp_valid_q;
  assign icb_rsp_rdata = rsp_rdata_q;
  assign icb_rsp_err   = rsp_err_q;
  assign clint_sft_irq = msip_q;
  assign clint_tmr_irq = tmr_irq_q;
  assign plic_ext_irq  = ext_irq_q;

  assign io_pads_gpioA_o_oval = gpioa_out_q;
  assign io_pads_gpioA_o_oe   = gpioa_oe_q;
  assign io_pads_gpioB_o_oval = gpiob_out_q;
  assign io_pads_gpioB_o_oe   = gpiob_oe_q;

  assign hfxoscen                        = 1'b1;
  assign lfxoscen                        = 1'b1;
  assign io_pads_jtag_TDO_o_oval         = 1'b0;
  assign io_pads_jtag_TDO_o_oe           = 1'b0;
  assign io_pads_qspi0_sck_o_oval        = 1'b0;
  assign io_pads_qspi0_cs_0_o_oval       = 1'b1;
  assign io_pads_qspi0_dq_0_o_oval       = 1'b0;
  assign io_pads_qspi0_dq_0_o_oe         = 1'b0;
  assign io_pads_qspi0_dq_1_o_oval       = 1'b0;
  assign io_pads_qspi0_dq_1_o_oe         = 1'b0;
  assign io_pads_qspi0_dq_2_o_oval       = 1'b0;
  assign io_pads_qspi0_dq_2_o_oe         = 1'b0;
  assign io_pads_qspi0_dq_3_o_oval       = 1'b0;
  assign io_pads_qspi0_dq_3_o_oe         = 1'b0;
  assign io_pads_aon_pmu_vddpaden_o_oval = 1'b1;
  assign io_pads_aon_pmu_padrst_o_oval   = padrst_q;

endmodule

// File: tb/tb_e203_soc_top.sv
// Directed bench for e203_soc_top: bus traffic checked by a response scoreboard, side outputs checked inline.
module tb_e203_soc_top;

`ifdef E203_GPIOB_EN
  localparam bit GPIOB = 1'b1;
`else
  localparam bit GPIOB = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1, lfclk = 1'b0;
  logic hfxoscen, lfxoscen;
  logic cmd_valid = 1'b0, cmd_ready, cmd_read = 1'b0;
  logic [11:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wmask = '0;
  logic rsp_valid, rsp_ready = 1'b1, rsp_err;
  logic [31:0] rsp_rdata;
  logic sft_irq, tmr_irq, ext_irq;
  logic [31:0] ga_ival = 32'h5A5A_0000, ga_oval, ga_oe, gb_ival = '0, gb_oval, gb_oe;
  logic tdo_oval, tdo_oe, sck, cs0;
  logic dq0_o, dq0_oe, dq1_o, dq1_oe, dq2_o, dq2_oe, dq3_o, dq3_oe;
  logic vddpaden, padrst;

  int checks = 0, errors = 0;
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  e203_soc_top #(.LF_SYNC_STAGES(2)) dut (
    .hfextclk(clk), .aon_erst(rst), .lfextclk(lfclk), .hfxoscen(hfxoscen), .lfxoscen(lfxoscen),
    .icb_cmd_valid(cmd_valid), .icb_cmd_ready(cmd_ready), .icb_cmd_addr(cmd_addr),
    .icb_cmd_read(cmd_read), .icb_cmd_wdata(cmd_wdata), .icb_cmd_wmask(cmd_wmask),
    .icb_rsp_valid(rsp_valid), .icb_rsp_ready(rsp_ready), .icb_rsp_rdata(rsp_rdata),
    .icb_rsp_err(rsp_err), .clint_sft_irq(sft_irq), .clint_tmr_irq(tmr_irq), .plic_ext_irq(ext_irq),
    .io_pads_gpioA_i_ival(ga_ival), .io_pads_gpioA_o_oval(ga_oval), .io_pads_gpioA_o_oe(ga_oe),
    .io_pads_gpioB_i_ival(gb_ival), .io_pads_gpioB_o_oval(gb_oval), .io_pads_gpioB_o_oe(gb_oe),
    .io_pads_jtag_TCK_i_ival(1'b0), .io_pads_jtag_TMS_i_ival(1'b1), .io_pads_jtag_TDI_i_ival(1'b1),
    .io_pads_jtag_TDO_o_oval(tdo_oval), .io_pads_jtag_TDO_o_oe(tdo_oe),
    .io_pads_qspi0_sck_o_oval(sck), .io_pads_qspi0_cs_0_o_oval(cs0),
    .io_pads_qspi0_dq_0_i_ival(1'b1), .io_pads_qspi0_dq_0_o_oval(dq0_o), .io_pads_qspi0_dq_0_o_oe(dq0_oe),
    .io_pads_qspi0_dq_1_i_ival(1'b0), .io_pads_qspi0_dq_1_o_oval(dq1_o), .io_pads_qspi0_dq_1_o_oe(dq1_oe),
    .io_pads_qspi0_dq_2_i_ival(1'b1), .io_pads_qspi0_dq_2_o_oval(dq2_o), .io_pads_qspi0_dq_2_o_oe(dq2_oe),
    .io_pads_qspi0_dq_3_i_ival(1'b0), .io_pads_qspi0_dq_3_o_oval(dq3_o), .io_pads_qspi0_dq_3_o_oe(dq3_oe),
    .io_pads_aon_pmu_dwakeup_n_i_ival(1'b1), .io_pads_bootrom_n_i_ival(1'b1),
    .io_pads_dbgmode0_n_i_ival(1'b0), .io_pads_dbgmode1_n_i_ival(1'b1), .io_pads_dbgmode2_n_i_ival(1'b0),
    .io_pads_aon_pmu_vddpaden_o_oval(vddpaden), .io_pads_aon_pmu_padrst_o_oval(padrst)
  );

  // Response monitor: every completed handshake is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected got rdata=%h err=%b, required no response", rsp_rdata, rsp_err);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        if ({rsp_rdata, rsp_err} !== e) begin
          errors++;
          $display("FAIL rsp got rdata=%h err=%b, required rdata=%h err=%b",
                   rsp_rdata, rsp_err, e[32:1], e[0]);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h, required %h", name, act, req);
    end
  endtask

  task automatic bus(input logic [11:0] a, input logic rd, input logic [31:0] wd,
                     input logic [3:0] wm, input logic [31:0] er, input logic ee,
                     input bit expect_rsp = 1'b1);
    int n;
    n = 0;
    if (expect_rsp) exp_q.push_back({er, ee});
    cmd_valid = 1'b1; cmd_addr = a; cmd_read = rd; cmd_wdata = wd; cmd_wmask = wm;
    while (!cmd_ready && n < 50) begin
      cycles(1);
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL bus_accept addr=%h got no cmd_ready in 50 cycles, required acceptance", a);
    end
    cycles(1);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      cycles(1);
      n++;
    end
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic lf_periods(input int n);
    repeat (n) begin
      lfclk = 1'b1; cycles(4);
      lfclk = 1'b0; cycles(4);
    end
    cycles(4);
  endtask

  initial begin
    bit seen;
    cycles(3);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_irqs", {61'd0, sft_irq, tmr_irq, ext_irq}, 64'd0);
    check("rst_padrst", 64'(padrst), 64'd1);
    check("rst_gpioA_oval", 64'(ga_oval), 64'd0);
    check("const_pads", {52'd0, hfxoscen, lfxoscen, tdo_oval, tdo_oe, sck, cs0, vddpaden,
                         dq0_o | dq1_o | dq2_o | dq3_o, dq0_oe | dq1_oe | dq2_oe | dq3_oe,
                         gb_oval[0], gb_oe[0], 1'b0},
          {52'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    rst = 1'b0;
    cycles(1);
    check("padrst_release", 64'(padrst), 64'd0);
    cycles(2);

    bus(12'h02C, 1'b1, 0, 4'h0, 32'hFFFF_FFFF, 1'b0);
    bus(12'h030, 1'b1, 0, 4'h0, 32'hFFFF_FFFF, 1'b0);
    check("tmr_irq_after_rst", 64'(tmr_irq), 64'd0);

    bus(12'h004, 1'b0, 32'hDEAD_BEA5, 4'b0001, 32'd0, 1'b0);
    bus(12'h008, 1'b0, 32'hFFFF_FFFF, 4'b1111, 32'd0, 1'b0);
    check("gpioA_oval", 64'(ga_oval), 64'h0000_00A5);
    check("gpioA_oe", 64'(ga_oe), 64'hFFFF_FFFF);
    bus(12'h004, 1'b1, 0, 4'h0, 32'h0000_00A5, 1'b0);
    bus(12'h004, 1'b0, 32'h1122_3344, 4'b1010, 32'd0, 1'b0);
    bus(12'h004, 1'b1, 0, 4'h0, 32'h1100_33A5, 1'b0);

    bus(12'h034, 1'b1, 0, 4'h0, 32'h0000_0015, 1'b0);
    bus(12'h034, 1'b0, 32'hFFFF_FFFF, 4'hF, 32'd0, 1'b0);
    bus(12'h034, 1'b1, 0, 4'h0, 32'h0000_0015, 1'b0);
    bus(12'h000, 1'b1, 0, 4'h0, 32'h5A5A_0000, 1'b0);

    bus(12'h02C, 1'b0, 32'd3, 4'hF, 32'd0, 1'b0);
    bus(12'h030, 1'b0, 32'd0, 4'hF, 32'd0, 1'b0);
    cycles(2);
    check("tmr_irq_below_cmp", 64'(tmr_irq), 64'd0);
    lf_periods(3);
    bus(12'h024, 1'b1, 0, 4'h0, 32'd3, 1'b0);
    bus(12'h028, 1'b1, 0, 4'h0, 32'd0, 1'b0);
    check("tmr_irq_at_cmp", 64'(tmr_irq), 64'd1);

    bus(12'h024, 1'b0, 32'hFFFF_FFFF, 4'hF, 32'd0, 1'b0);
    bus(12'h028, 1'b0, 32'hFFFF_FFFF, 4'hF, 32'd0, 1'b0);
    lf_periods(1);
    bus(12'h024, 1'b1, 0, 4'h0, 32'd0, 1'b0);
    bus(12'h028, 1'b1, 0, 4'h0, 32'd0, 1'b0);
    check("tmr_irq_after_wrap", 64'(tmr_irq), 64'd0);

    bus(12'h00C, 1'b0, 32'd1, 4'hF, 32'd0, 1'b0);
    cycles(3);
    check("ext_irq_masked", 64'(ext_irq), 64'd0);
    ga_ival = 32'h5A5A_0001;
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      cycles(1);
      seen = ext_irq;
    end
    check("ext_irq_within_4", 64'(seen), 64'd1);
    check("sft_irq_before", 64'(sft_irq), 64'd0);
    bus(12'h020, 1'b0, 32'd1, 4'hF, 32'd0, 1'b0);
    check("sft_irq_after", 64'(sft_irq), 64'd1);

    bus(12'h040, 1'b1, 0, 4'h0, 32'd0, 1'b1);
    bus(12'h006, 1'b1, 0, 4'h0, 32'd0, 1'b1);
    drain();
    rsp_ready = 1'b0;
    bus(12'h004, 1'b1, 0, 4'h0, 32'h1100_33A5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("hold_rsp_valid", 64'(rsp_valid), 64'd1);
      check("hold_cmd_ready", 64'(cmd_ready), 64'd0);
      check("hold_rdata", 64'(rsp_rdata), 64'h1100_33A5);
      cycles(1);
    end
    rsp_ready = 1'b1;
    drain();

    bus(12'h014, 1'b0, 32'hFFFF_FFFF, 4'hF, 32'd0, !GPIOB);
    check("gpioB_oval", 64'(gb_oval), GPIOB ? 64'hFFFF_FFFF : 64'd0);
    bus(12'h010, 1'b1, 0, 4'h0, 32'd0, !GPIOB);
    drain();

    rsp_ready = 1'b0;
    bus(12'h004, 1'b1, 0, 4'h0, 32'd0, 1'b0, 1'b0);
    check("pending_before_rst", 64'(rsp_valid), 64'd1);
    rst = 1'b1;
    cycles(1);
    check("rst_drops_rsp", 64'(rsp_valid), 64'd0);
    check("rst_clears_gpio", 64'(ga_oval), 64'd0);
    check("rst_clears_msip", 64'(sft_irq), 64'd0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    cycles(2);
    check("no_rsp_after_rst", 64'(rsp_valid), 64'd0);
    bus(12'h02C, 1'b1, 0, 4'h0, 32'hFFFF_FFFF, 1'b0);
    bus(12'h004, 1'b1, 0, 4'h0, 32'd0, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/e203_soc_top.md
E203_SOC_TOP -- requirements
Module: e203_soc_top

Interface
REQ-001 SHALL have parameter LF_SYNC_STAGES, default 2, sync flops for lfextclk into hfextclk domain (min 2).
REQ-002 SHALL have ports: hfextclk in 1 sole clock, all logic posedge; aon_erst in 1 reset, synchronous, active-high.
REQ-003 lfextclk in 1 low-freq timebase, sampled as data; hfxoscen, lfxoscen out 1 oscillator enables.
REQ-004 icb_cmd_valid in 1; icb_cmd_ready out 1; icb_cmd_addr in 12; icb_cmd_read in 1; icb_cmd_wdata in 32; icb_cmd_wmask in 4 -- register-bus command from core cluster.
REQ-005 icb_rsp_valid out 1; icb_rsp_ready in 1; icb_rsp_rdata out 32; icb_rsp_err out 1 -- response channel.
REQ-006 clint_sft_irq, clint_tmr_irq, plic_ext_irq out 1 each, interrupts to core.
REQ-007 io_pads_gpioA_i_ival in 32; io_pads_gpioA_o_oval, io_pads_gpioA_o_oe out 32; gpioB same triple.
REQ-008 io_pads_jtag_TCK/TMS/TDI_i_ival in 1; io_pads_jtag_TDO_o_oval, _o_oe out 1.
REQ-009 io_pads_qspi0_sck_o_oval, io_pads_qspi0_cs_0_o_oval out 1; qspi0_dq_0..3: _i_ival in 1, _o_oval/_o_oe out 1.
REQ-010 io_pads_aon_pmu_dwakeup_n_i_ival, io_pads_bootrom_n_i_ival, io_pads_dbgmode0/1/2_n_i_ival in 1; io_pads_aon_pmu_vddpaden_o_oval, io_pads_aon_pmu_padrst_o_oval out 1.

Function
REQ-011 Constant pads: hfxoscen=1, lfxoscen=1, TDO oval=0 oe=0, qspi sck=0, cs_0=1, all dq oval=0 oe=0, vddpaden=1; padrst SHALL equal aon_erst registered one cycle.
REQ-012 Bus: icb_cmd_ready = !icb_rsp_valid | icb_rsp_ready; accepted command -> icb_rsp_valid next cycle, held with rdata/err stable until icb_rsp_ready; one outstanding.
REQ-013 Writes apply at acceptance, per byte where wmask bit=1; read data reflects state before same-cycle updates.
REQ-014 Map (addr[11:2], word aligned): 0x00 GPIOA_IN RO; 0x04 GPIOA_OUT RW; 0x08 GPIOA_OE RW; 0x0C GPIOA_IRQ_EN RW; 0x10-0x1C GPIOB same layout; 0x20 MSIP bit0 RW; 0x24/0x28 MTIME lo/hi RW; 0x2C/0x30 MTIMECMP lo/hi RW; 0x34 STATUS RO.
REQ-015 Unmapped address or addr[1:0]!=0 -> err=1, rdata=0, no state change; writes to RO regs ignored, err=0.
REQ-016 GPIO inputs SHALL pass 2-flop sync; GPIOx_IN returns synced value; o_oval/o_oe driven directly from OUT/OE regs.
REQ-017 plic_ext_irq = |(GPIOA_IN & GPIOA_IRQ_EN) | |(GPIOB_IN & GPIOB_IRQ_EN), registered (1-cycle latency).
REQ-018 clint_sft_irq = MSIP[0].
REQ-019 lfextclk SHALL pass LF_SYNC_STAGES flops; each synced rising edge increments 64-bit MTIME by 1 next cycle, wrapping 0xFFFF_FFFF_FFFF_FFFF->0; bus write to same half in same cycle wins over increment.
REQ-020 clint_tmr_irq = (MTIME >= MTIMECMP) unsigned 64-bit, registered.
REQ-021 STATUS: bit0 bootrom_n, bits3:1 dbgmode2..0_n, bit4 dwakeup_n, synced; other bits 0.
REQ-022 JTAG TCK/TMS/TDI inputs are ignored.

Reset
REQ-023 While aon_erst=1 at hfextclk edge: GPIO OUT/OE/IRQ_EN=0, MSIP=0, MTIME=0, MTIMECMP=0xFFFF_FFFF_FFFF_FFFF, sync flops=0, icb_rsp_valid=0, rdata=0, err=0, all irq outputs=0.
REQ-024 Reset asserted with response pending SHALL drop icb_rsp_valid next edge; command is discarded.

Configuration
REQ-025 Macro E203_GPIOB_EN: defined -> GPIOB regs per REQ-014/016/017; undefined -> gpioB o_oval/o_oe=0, 0x10-0x1C unmapped (err=1), GPIOB absent from ext irq.

Verification
REQ-026 Reset, read 0x2C/0x30 -> 0xFFFFFFFF both, err=0; clint_tmr_irq=0.
REQ-027 Write 0x04=0x0000_00A5 wmask=4'b0001, then 0x08=0xFFFF_FFFF -> gpioA_o_oval=0xA5, o_oe=all ones; read 0x04 -> 0xA5.
REQ-028 Write MTIMECMP=3 (hi=0), toggle lfextclk 3 full periods -> MTIME reads 3, clint_tmr_irq=1.
REQ-029 IRQ_EN=0x1, gpioA_i_ival=0x1 -> plic_ext_irq=1 within 4 cycles; write 0x20=1 -> clint_sft_irq=1 next cycle.
REQ-030 Read 0x40 -> err=1, rdata=0; hold icb_rsp_ready=0 3 cycles -> rsp_valid held, cmd_ready=0.
REQ-031 Without E203_GPIOB_EN, write 0x14 -> err=1, gpioB_o_oval stays 0.
